// File: rtl/leaf_sched_pkg.sv
// Shared types, default sizes and the rotating-priority pick function used by
// the leaf schedulers of the generated sub-hierarchy.
package leaf_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int NUM_REQ_DEF = 5;
    localparam int TIMEOUT_DEF = 64;
    localparam int MAX_REQ     = 16;

    // First set request bit at or after (last+1) mod n, scanning upward with
    // wrap. The loop walks downward so the nearest candidate is assigned last
    // and wins. Returns 0 when no request is set; callers qualify with |req.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [3:0]         last,
                                           input int                 n);
        logic [3:0] idx;
        int         c;
        idx = '0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                c = int'(last) + k;
                if (c >= n) c = c - n;
                if (req[4'(c)]) idx = 4'(c);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating-priority encoder: picks the first requester after
// the previous winner, wrapping at NUM_REQ.
module rr_prio_pick
    import leaf_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    logic [MAX_REQ-1:0] w_req_ext;
    logic [3:0]         w_last_ext;
    logic [3:0]         w_pick;

    assign w_req_ext  = MAX_REQ'(i_req);
    assign w_last_ext = 4'(i_last);
    assign w_pick     = rr_pick(w_req_ext, w_last_ext, NUM_REQ);
    assign o_idx      = IDX_W'(w_pick);
    assign o_valid    = |i_req;

endmodule

// File: rtl/leaf_rr_scheduler.sv
// Round-robin owner scheduler for the leaf instances: one exclusive owner at a
// time, released by done, request drop or watchdog, with a bubble between
// grants. All outputs are registered.
module leaf_rr_scheduler
    import leaf_sched_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    parameter  int TIMEOUT = TIMEOUT_DEF,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               busy,
    output logic               timeout,
    output logic [IDX_W-1:0]   timeout_idx
);

    localparam int WD_W = $clog2(TIMEOUT);

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx_nxt;
    logic [IDX_W-1:0]   r_last, w_last_nxt;
    logic [IDX_W-1:0]   r_to_idx, w_to_idx_nxt;
    logic               r_to, w_to_nxt;
    logic               r_busy;
    logic [WD_W-1:0]    r_wd, w_wd_nxt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_vld;
    logic               w_own_done, w_own_req, w_wd_max;

    rr_prio_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_vld)
    );

    // Only the current owner's bits matter while a grant is held.
    assign w_own_done = done[r_gnt_idx];
    assign w_own_req  = req[r_gnt_idx];
    assign w_wd_max   = (r_wd == WD_W'(TIMEOUT - 1));

    // Next-state and next-output logic; every OWN exit goes through IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_idx_nxt = r_gnt_idx;
        w_last_nxt    = r_last;
        w_to_nxt      = 1'b0;
        w_to_idx_nxt  = r_to_idx;
        w_wd_nxt      = r_wd;
        case (r_state)
            IDLE: begin
                w_gnt_nxt = '0;
                if (w_pick_vld) begin
                    w_state_nxt   = OWN;
                    w_gnt_nxt     = NUM_REQ'(1) << w_pick_idx;
                    w_gnt_idx_nxt = w_pick_idx;
                    w_last_nxt    = w_pick_idx;
                    w_wd_nxt      = '0;
                end
            end
            OWN: begin
                if (w_own_done || !w_own_req || w_wd_max) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    // A done in the final cycle is a normal release.
                    if (w_wd_max && !w_own_done) begin
                        w_to_nxt     = 1'b1;
                        w_to_idx_nxt = r_gnt_idx;
                    end
                end else begin
                    w_wd_nxt = r_wd + WD_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Output, pointer and watchdog registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_last    <= IDX_W'(NUM_REQ - 1);
            r_to      <= 1'b0;
            r_to_idx  <= '0;
            r_busy    <= 1'b0;
            r_wd      <= '0;
        end else begin
            r_gnt     <= w_gnt_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_last    <= w_last_nxt;
            r_to      <= w_to_nxt;
            r_to_idx  <= w_to_idx_nxt;
            r_busy    <= |w_gnt_nxt;
            r_wd      <= w_wd_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign gnt_idx     = r_gnt_idx;
    assign busy        = r_busy;
    assign timeout     = r_to;
    assign timeout_idx = r_to_idx;

endmodule

// File: tb/tb_leaf_rr_scheduler.sv
// Directed bench for leaf_rr_scheduler with a per-cycle reference model of
// the owner/rotation/watchdog rules and literal checks at key points.
module tb_leaf_rr_scheduler;

    localparam int N = 5;
    localparam int T = 8;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  done = '0;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          busy;
    logic          timeout;
    logic [IW-1:0] timeout_idx;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // reference model state
    int m_owner = -1;
    int m_last  = N - 1;
    int m_cnt   = 0;
    int m_gidx  = 0;
    int m_toidx = 0;
    bit m_to    = 1'b0;

    leaf_rr_scheduler #(.NUM_REQ(N), .TIMEOUT(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .busy        (busy),
        .timeout     (timeout),
        .timeout_idx (timeout_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: owner lifetime from the rules (who wins, how long, why released)
    always @(posedge clk) begin
        int c;
        if (!rst_n) begin
            m_owner = -1; m_last = N - 1; m_cnt = 0;
            m_gidx = 0; m_toidx = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (req[c] && m_owner < 0) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_last = m_owner; m_gidx = m_owner; m_cnt = 0;
            end
        end else begin
            m_to = (m_cnt == T - 1) && !done[m_owner];
            if (done[m_owner] || !req[m_owner] || m_cnt == T - 1) begin
                if (m_to) m_toidx = m_owner;
                m_owner = -1;
            end else begin
                m_cnt++;
            end
        end
    end

    // compare every cycle on the falling edge
    always @(negedge clk) begin
        if (started) begin
            chk("sb_gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("sb_busy", 32'(busy), 32'(m_owner >= 0));
            chk("sb_timeout", 32'(timeout), 32'(m_to));
            chk("sb_timeout_idx", 32'(timeout_idx), 32'(m_toidx));
            if (m_owner >= 0) chk("sb_gnt_idx", 32'(gnt_idx), 32'(m_gidx));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        int seq[4];
        seq = '{2, 3, 4, 0};

        // reset state
        step(2);
        started = 1'b1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_gnt_idx", 32'(gnt_idx), 32'h0);
        chk("rst_timeout_idx", 32'(timeout_idx), 32'h0);

        // reset priority
        rst_n = 1'b1; req = 5'b11111;
        step(1);
        chk("t1_first", 32'(gnt), 32'h01);
        done = 5'b00001;
        step(1); done = '0;
        chk("t1_bubble", 32'(gnt), 32'h00);
        step(1);
        chk("t1_second", 32'(gnt), 32'h02);

        // fairness: zero hold, grants two cycles apart
        for (int i = 0; i < 4; i++) begin
            done = (i == 0) ? 5'b00010 : (5'b00001 << seq[i-1]);
            step(1); done = '0;
            chk("t2_bubble", 32'(gnt), 32'h00);
            step(1);
            chk("t2_order", 32'(gnt), 32'd1 << seq[i]);
        end

        // wrap-around from last=3
        done = 5'b00001; req = 5'b01000;
        step(1); done = '0;
        step(1);
        chk("t3_own3", 32'(gnt), 32'h08);
        done = 5'b01000; req = 5'b00101;
        step(1); done = '0;
        step(1);
        chk("t3_wrap", 32'(gnt), 32'h01);

        // watchdog timeout on requester 2
        done = 5'b00001; req = 5'b00100;
        step(1); done = '0;
        step(1);
        chk("t4_own2", 32'(gnt), 32'h04);
        req = 5'b00110;
        n = 0;
        while (gnt[2] && n < 20) begin
            n++;
            step(1);
        end
        chk("t4_span", 32'(n), 32'd8);
        chk("t4_pulse", 32'(timeout), 32'h1);
        chk("t4_idx", 32'(timeout_idx), 32'h2);
        step(1);
        chk("t4_next", 32'(gnt), 32'h02);
        chk("t4_pulse_end", 32'(timeout), 32'h0);

        // done coincident with final watchdog cycle; non-owner done ignored
        done = 5'b00010; req = 5'b00100;
        step(1); done = '0;
        step(1);
        chk("t5_own2", 32'(gnt), 32'h04);
        done = 5'b10000;
        step(1); done = '0;
        chk("t5_nonowner", 32'(gnt), 32'h04);
        step(6);
        chk("t5_still", 32'(gnt), 32'h04);
        done = 5'b00100;
        step(1); done = '0;
        chk("t5_release", 32'(gnt), 32'h00);
        chk("t5_no_to", 32'(timeout), 32'h0);

        // reset mid-grant
        req = 5'b01000;
        step(1);
        chk("t6_own3", 32'(gnt), 32'h08);
        rst_n = 1'b0;
        step(1);
        chk("t6_gnt", 32'(gnt), 32'h00);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_gnt_idx", 32'(gnt_idx), 32'h0);
        chk("t6_timeout_idx", 32'(timeout_idx), 32'h0);
        rst_n = 1'b1;
        step(1);
        chk("t6_regrant", 32'(gnt), 32'h08);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
